// File: rtl/div_pipe_8bit_if.sv
// Operand/result bundle for the pipelined divider: the master issues operands,
// the slave (the divider) returns results with a fixed latency.
interface div_pipe_8bit_if #(parameter int size = 8) ();
    logic              div_en_in;
    logic [2*size-1:0] div_a;
    logic [size-1:0]   div_b;
    logic              div_en_out;
    logic [2*size-1:0] div_quo;
    logic [size-1:0]   div_rem;
    logic              div_zero;

    modport master (
        output div_en_in, div_a, div_b,
        input  div_en_out, div_quo, div_rem, div_zero
    );

    modport slave (
        input  div_en_in, div_a, div_b,
        output div_en_out, div_quo, div_rem, div_zero
    );
endinterface

// File: rtl/div_pipe_8bit.sv
// Fully pipelined unsigned restoring divider: 2*size-bit dividend over a
// size-bit divisor, two quotient bits per stage, one operation per clock.
module div_pipe_8bit #(
    parameter int size = 8
) (
    input logic            clk,
    input logic            rst_n,
    div_pipe_8bit_if.slave bus
);

    // Handshake: div_en_in qualifies div_a/div_b in the cycle it is high; the
    // matching result is qualified by a one-cycle div_en_out exactly size+2
    // edges later. There is no back-pressure, so no ready signal exists.

    logic [size-1:0]   rem_q [0:size];
    logic [2*size-1:0] quo_q [0:size];
    logic [2*size-1:0] dvd_q [0:size];
    logic [size-1:0]   dvs_q [0:size];
    logic [size-1:0]   alo_q [0:size];
    logic              zro_q [0:size];
    logic [size+1:0]   vld_q;

    logic [size-1:0]   rem_nx [1:size];
    logic [2*size-1:0] quo_nx [1:size];
    logic [2*size-1:0] dvd_nx [1:size];

    logic [2*size-1:0] fin_quo;
    logic [size-1:0]   fin_rem;
    logic [size-1:0]   fin_alo;
    logic              fin_zero;

    logic              en_out_q;
    logic [2*size-1:0] quo_out_q;
    logic [size-1:0]   rem_out_q;
    logic              zero_out_q;

    // Two cascaded restoring steps per stage; the trial value is size+1 bits
    // wide so the shifted-in bit never overflows the comparison.
    always_comb begin : stage_calc
        logic [size-1:0]   r;
        logic [2*size-1:0] q;
        logic [2*size-1:0] d;
        logic [size:0]     t;
        r = '0;
        q = '0;
        d = '0;
        t = '0;
        for (int s = 1; s <= size; s++) begin
            r = rem_q[s-1];
            q = quo_q[s-1];
            d = dvd_q[s-1];
            for (int k = 0; k < 2; k++) begin
                t = {r, d[2*size-1]};
                d = d << 1;
                if (t >= {1'b0, dvs_q[s-1]}) begin
                    t = t - {1'b0, dvs_q[s-1]};
                    q = {q[2*size-2:0], 1'b1};
                end else begin
                    q = {q[2*size-2:0], 1'b0};
                end
                r = t[size-1:0];
            end
            rem_nx[s] = r;
            quo_nx[s] = q;
            dvd_nx[s] = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s <= size; s++) begin
                rem_q[s] <= '0;
                quo_q[s] <= '0;
                dvd_q[s] <= '0;
                dvs_q[s] <= '0;
                alo_q[s] <= '0;
                zro_q[s] <= 1'b0;
            end
            fin_quo    <= '0;
            fin_rem    <= '0;
            fin_alo    <= '0;
            fin_zero   <= 1'b0;
            en_out_q   <= 1'b0;
            quo_out_q  <= '0;
            rem_out_q  <= '0;
            zero_out_q <= 1'b0;
        end else begin
            vld_q <= {vld_q[size:0], bus.div_en_in};

            rem_q[0] <= '0;
            quo_q[0] <= '0;
            if (bus.div_en_in) begin
                dvd_q[0] <= bus.div_a;
                dvs_q[0] <= bus.div_b;
                alo_q[0] <= bus.div_a[size-1:0];
                zro_q[0] <= (bus.div_b == '0);
            end else begin
                dvd_q[0] <= '0;
                dvs_q[0] <= '0;
                alo_q[0] <= '0;
                zro_q[0] <= 1'b0;
            end

            for (int s = 1; s <= size; s++) begin
                rem_q[s] <= rem_nx[s];
                quo_q[s] <= quo_nx[s];
                dvd_q[s] <= dvd_nx[s];
                dvs_q[s] <= dvs_q[s-1];
                alo_q[s] <= alo_q[s-1];
                zro_q[s] <= zro_q[s-1];
            end

            fin_quo  <= quo_q[size];
            fin_rem  <= rem_q[size];
            fin_alo  <= alo_q[size];
            fin_zero <= zro_q[size];

            // Outputs stay zero unless the valid tap marks a real result.
            en_out_q <= vld_q[size+1];
            if (vld_q[size+1] && fin_zero) begin
                quo_out_q  <= '1;
                rem_out_q  <= fin_alo;
                zero_out_q <= 1'b1;
            end else if (vld_q[size+1]) begin
                quo_out_q  <= fin_quo;
                rem_out_q  <= fin_rem;
                zero_out_q <= 1'b0;
            end else begin
                quo_out_q  <= '0;
                rem_out_q  <= '0;
                zero_out_q <= 1'b0;
            end
        end
    end

    assign bus.div_en_out = en_out_q;
    assign bus.div_quo    = quo_out_q;
    assign bus.div_rem    = rem_out_q;
    assign bus.div_zero   = zero_out_q;

endmodule

// File: tb/tb_div_pipe_8bit.sv
// Self-checking bench for div_pipe_8bit: directed cases, streaming, mid-flight
// reset and a random run scored cycle-by-cycle against an arithmetic model.
module tb_div_pipe_8bit;

    localparam int LAT = 10;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [25:0] exp_q[$];

    div_pipe_8bit_if #(.size(8)) bus ();

    div_pipe_8bit #(.size(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] out_vec();
        return {bus.div_en_out, bus.div_zero, bus.div_quo, bus.div_rem};
    endfunction

    // Expected output word {en, zero, quo, rem} from plain integer division.
    function automatic logic [25:0] model(input logic en, input logic [15:0] a, input logic [7:0] b);
        logic [15:0] q;
        logic [7:0]  r;
        if (!en) return '0;
        if (b == 8'd0) return {2'b11, 16'hFFFF, a[7:0]};
        q = a / {8'd0, b};
        r = 8'(a % {8'd0, b});
        return {2'b10, q, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic [15:0] a, input logic [7:0] b);
        bus.div_en_in = en;
        bus.div_a     = a;
        bus.div_b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic ez);
        drive(1'b1, a, b);
        bus.div_en_in = 1'b0;
        for (int n = 0; n <= 11; n++) begin
            @(negedge clk);
            if (n == LAT - 1) check({tag, "_before"}, 32'(out_vec()), 32'd0);
            if (n == LAT)     check(tag, 32'(out_vec()), 32'({1'b1, ez, eq, er}));
            if (n == LAT + 1) check({tag, "_after"}, 32'(out_vec()), 32'd0);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge rst_n) exp_q.delete();

    always @(posedge clk) begin
        if (rst_n) exp_q.push_back(model(bus.div_en_in, bus.div_a, bus.div_b));
    end

    always @(negedge clk) begin
        logic [25:0] exp;
        if (exp_q.size() == LAT + 1) exp = exp_q.pop_front();
        else exp = '0;
        check("stream", 32'(out_vec()), 32'(exp));
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.div_en_in = 1'b0;
        bus.div_a     = '0;
        bus.div_b     = '0;
        #3;
        check("reset_out", 32'(out_vec()), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        single("basic",     16'd1000,  8'd7,   16'd142,   8'd6,    1'b0);
        single("max_255",   16'd65535, 8'd255, 16'd257,   8'd0,    1'b0);
        single("max_1",     16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0);
        single("small_num", 16'd100,   8'd200, 16'd0,     8'd100,  1'b0);
        single("zero_num",  16'd0,     8'd9,   16'd0,     8'd0,    1'b0);
        single("div_zero",  16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1);

        // Three back-to-back ops, one idle slot, then one more.
        drive(1'b1, 16'd1000,  8'd7);
        drive(1'b1, 16'h1234,  8'd0);
        drive(1'b1, 16'd50000, 8'd123);
        drive(1'b0, 16'($urandom), 8'($urandom));
        drive(1'b1, 16'd255,   8'd16);
        bus.div_en_in = 1'b0;
        for (int m = 4; m <= 15; m++) begin
            @(negedge clk);
            case (m)
                9:  check("strm_pre",  32'(out_vec()), 32'd0);
                10: check("strm_op0",  32'(out_vec()), 32'({2'b10, 16'd142, 8'd6}));
                11: check("strm_op1",  32'(out_vec()), 32'({2'b11, 16'hFFFF, 8'h34}));
                12: check("strm_op2",  32'(out_vec()), 32'({2'b10, 16'd406, 8'd62}));
                13: check("strm_gap",  32'(out_vec()), 32'd0);
                14: check("strm_op3",  32'(out_vec()), 32'({2'b10, 16'd15, 8'd15}));
                15: check("strm_post", 32'(out_vec()), 32'd0);
                default: ;
            endcase
        end

        // Mid-flight reset while the first result is on the outputs.
        for (int i = 0; i < 4; i++) drive(1'b1, 16'($urandom), 8'($urandom_range(1, 255)));
        for (int i = 0; i < 6; i++) drive(1'b0, 16'($urandom), 8'($urandom));
        @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(bus.div_en_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(out_vec()), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.div_en_out) seen++;
        end
        check("rst_no_stale", 32'(seen), 32'd0);

        // Random operands with random valid gaps.
        for (int i = 0; i < 10000; i++) begin
            logic       en;
            logic [7:0] b;
            en = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            drive(en, 16'($urandom), b);
        end
        bus.div_en_in = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        #1;

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
